// File: rtl/mips_run_controller.sv
// Run sequencer for the MIPS pipelined core: holds the core in reset, models pipeline
// occupancy to count retirements, and flags Done. Optional watchdog: RUN_CTRL_TIMEOUT_EN.
module mips_run_controller #(
  parameter int PIPE_DEPTH     = 5,
  parameter int CNT_W          = 16,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [CNT_W-1:0] Target_Instr,
  input  logic             Stall,
  input  logic             Bubble,
  output logic             Core_Reset,
  output logic             Busy,
  output logic             Done,
  output logic             Retire,
  output logic [CNT_W-1:0] Cycle_Count,
  output logic [CNT_W-1:0] Retired_Count,
  output logic             Timeout
);

  localparam int VW = PIPE_DEPTH - 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  if (PIPE_DEPTH < 2 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mips_run_controller: illegal parameter setting");
  end

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [VW-1:0]    v;
  logic [VW:0]      v_shift;
  logic [CNT_W-1:0] target_q, issued, cycle_q, retired_q;
  logic [HW-1:0]    hold_cnt;
  logic             busy_q, done_q, core_run_q;
  logic             inject, retire, last_retire, hold_entry, run_entry, wd_expire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  assign inject      = (state == RUN) && !Stall && !Bubble && (issued < target_q);
  assign retire      = (state == RUN) && !Stall && v[VW-1];
  assign last_retire = retire && ((retired_q + 1'b1) == target_q);
  assign hold_entry  = (state_nxt == HOLD) && (state != HOLD);
  assign run_entry   = (state_nxt == RUN) && (state != RUN);
  // Concatenate then drop the WB bit so a one-stage vector still elaborates.
  assign v_shift     = {v, inject};

`ifdef RUN_CTRL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
  logic          timeout_q;

  assign wd_expire = (state == RUN) && !retire && (wd == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wd        <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (hold_entry)     timeout_q <= 1'b0;
      else if (wd_expire) timeout_q <= 1'b1;
      if (run_entry || retire) wd <= '0;
      else if (state == RUN)   wd <= wd + 1'b1;
    end
  end

  assign Timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign Timeout   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = HOLD;
      HOLD: if (hold_cnt == HOLD_LAST) state_nxt = (target_q == '0) ? DONE : RUN;
      RUN:  if (last_retire || wd_expire) state_nxt = DONE;
      DONE: if (Start) state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_run_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy_q     <= (state_nxt == HOLD) || (state_nxt == RUN);
      done_q     <= (state_nxt == DONE);
      core_run_q <= (state_nxt == RUN) || (state_nxt == DONE);
    end
  end

  // Target is only consulted after HOLD entry, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (hold_entry) target_q <= Target_Instr;
  end

  always_ff @(posedge Clk) begin
    if (Reset || hold_entry) begin
      v         <= '0;
      issued    <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
      hold_cnt  <= '0;
    end else begin
      if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (state == RUN) begin
        cycle_q <= sat_inc(cycle_q);
        if (!Stall) begin
          v <= v_shift[VW-1:0];
          if (inject)   issued    <= issued + 1'b1;
          if (v[VW-1])  retired_q <= retired_q + 1'b1;
        end
      end
    end
  end

  assign Core_Reset    = core_run_q;
  assign Busy          = busy_q;
  assign Done          = done_q;
  assign Retire        = retire;
  assign Cycle_Count   = cycle_q;
  assign Retired_Count = retired_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// Scoreboard bench for mips_run_controller: stimulus queues expected run results,
// a negedge monitor tracks each RUN phase and compares when Done rises.
module tb_mips_run_controller;

  localparam int CW = 4;

`ifdef RUN_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset, Start, Stall, Bubble;
  logic [CW-1:0] Target_Instr;
  logic          Core_Reset, Busy, Done, Retire, Timeout;
  logic [CW-1:0] Cycle_Count, Retired_Count;

  mips_run_controller #(
    .PIPE_DEPTH(5), .CNT_W(CW), .HOLD_CYCLES(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Target_Instr(Target_Instr),
    .Stall(Stall), .Bubble(Bubble), .Core_Reset(Core_Reset), .Busy(Busy),
    .Done(Done), .Retire(Retire), .Cycle_Count(Cycle_Count),
    .Retired_Count(Retired_Count), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          kind;   // 0: completed run, 1: reset-state snapshot
    string       name;
    int          ret;
    int          cyc;
    int          len;
    logic [31:0] mask;
    logic        to;
  } exp_t;

  exp_t        q[$];
  int          n_cmp, n_err;
  int          snap_seq;
  int          mon_cyc, mon_snap, mon_wait;
  logic [31:0] mon_mask;
  logic        mon_prev_done;
  exp_t        mon_e;

  task automatic chk(input string nm, input longint act, input longint exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic push(input int kind, input string nm, input int ret, input int cyc,
                      input int len, input logic [31:0] mask, input logic to);
    exp_t e;
    e.kind = kind; e.name = nm; e.ret = ret; e.cyc = cyc;
    e.len = len; e.mask = mask; e.to = to;
    q.push_back(e);
  endtask

  // Monitor: the only process that compares or touches the counters.
  initial begin
    n_cmp = 0; n_err = 0; mon_cyc = 0; mon_snap = 0; mon_wait = 0;
    mon_mask = '0; mon_prev_done = 1'b0;
    forever begin
      @(negedge Clk);
      if (Busy && !Core_Reset) begin
        mon_cyc = 0; mon_mask = '0;
      end else if (Busy && Core_Reset) begin
        if (Retire && mon_cyc < 32) mon_mask[mon_cyc] = 1'b1;
        mon_cyc++;
      end
      if (snap_seq != mon_snap) begin
        mon_snap = snap_seq;
        if (q.size() > 0 && q[0].kind == 1) begin
          mon_e = q.pop_front(); mon_wait = 0;
          chk({mon_e.name, " core_reset"}, Core_Reset, 0);
          chk({mon_e.name, " busy"}, Busy, 0);
          chk({mon_e.name, " done"}, Done, 0);
          chk({mon_e.name, " retire"}, Retire, 0);
          chk({mon_e.name, " timeout"}, Timeout, 0);
          chk({mon_e.name, " cycle_count"}, Cycle_Count, 0);
          chk({mon_e.name, " retired_count"}, Retired_Count, 0);
        end else begin
          n_cmp++; n_err++;
          $display("FAIL snapshot: no reset record queued (got queue size %0d, required >0)", q.size());
        end
      end
      if (Done && !mon_prev_done) begin
        if (q.size() > 0 && q[0].kind == 0) begin
          mon_e = q.pop_front(); mon_wait = 0;
          chk({mon_e.name, " retired_count"}, Retired_Count, mon_e.ret);
          chk({mon_e.name, " cycle_count"}, Cycle_Count, mon_e.cyc);
          chk({mon_e.name, " run_length"}, mon_cyc, mon_e.len);
          chk({mon_e.name, " retire_cycles"}, mon_mask, mon_e.mask);
          chk({mon_e.name, " timeout"}, Timeout, mon_e.to);
        end else begin
          n_cmp++; n_err++;
          $display("FAIL done: unexpected Done rise (got 1, required 0)");
        end
      end
      mon_prev_done = Done;
      if (q.size() > 0) begin
        mon_wait++;
        if (mon_wait > 300) begin
          n_cmp++; n_err++;
          $display("FAIL %s: no DUT response within 300 cycles (got none, required one)", q[0].name);
          void'(q.pop_front());
          mon_wait = 0;
        end
      end else begin
        mon_wait = 0;
      end
    end
  end

  // One run from IDLE/DONE: Start, HOLD, then 32 cycles of per-RUN-cycle stimulus.
  task automatic do_run(input string nm, input int tgt, input logic [31:0] stall_m,
                        input logic [31:0] bub_m, input logic [31:0] start_m,
                        input int ret, input int cyc, input int len,
                        input logic [31:0] mask, input logic to);
    push(0, nm, ret, cyc, len, mask, to);
    Start = 1'b1; Target_Instr = CW'(tgt);
    @(posedge Clk); #1 Start = 1'b0;
    @(posedge Clk); #1;
    for (int c = 0; c < 32; c++) begin
      Stall = stall_m[c]; Bubble = bub_m[c]; Start = start_m[c];
      if (start_m[c]) Target_Instr = CW'(9);
      @(posedge Clk); #1;
    end
    Stall = 1'b0; Bubble = 1'b0; Start = 1'b0;
    for (int k = 0; k < 200 && !Done; k++) begin
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    snap_seq = 0;
    Reset = 1'b1; Start = 1'b0; Stall = 1'b0; Bubble = 1'b0; Target_Instr = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    push(1, "power_on_reset", 0, 0, 0, '0, 1'b0);
    snap_seq++;
    @(posedge Clk); #1;

    do_run("basic_t3",      3, 32'h0, 32'h0, 32'h0, 3, 7, 7, 32'h0000_0070, 1'b0);
    do_run("stall_t3",      3, 32'hC, 32'h0, 32'h0, 3, 9, 9, 32'h0000_01C0, 1'b0);
    do_run("bubble_t2",     2, 32'h0, 32'h1, 32'h0, 2, 7, 7, 32'h0000_0060, 1'b0);
    do_run("zero_target",   0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0,         1'b0);

    // Reset during RUN cycle 3 must return to IDLE in one edge.
    Start = 1'b1; Target_Instr = CW'(3);
    @(posedge Clk); #1 Start = 1'b0;
    @(posedge Clk); #1;
    repeat (3) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    push(1, "midrun_reset", 0, 0, 0, '0, 1'b0);
    snap_seq++;
    @(posedge Clk); #1;

    do_run("after_reset_start_ignored", 3, 32'h0, 32'h0, 32'h2, 3, 7, 7, 32'h0000_0070, 1'b0);
    do_run("stall_over_bubble_t1",      1, 32'h1, 32'h1, 32'h0, 1, 6, 6, 32'h0000_0020, 1'b0);
    do_run("max_target_sat",           15, 32'h0, 32'h0, 32'h0, 15, 15, 19, 32'h0007_FFF0, 1'b0);
    if (TO_EN) begin
      do_run("watchdog",  3, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 8, 8, 32'h0, 1'b1);
      do_run("post_watchdog", 3, 32'h0, 32'h0, 32'h0, 3, 7, 7, 32'h0000_0070, 1'b0);
    end else begin
      do_run("long_stall_sat", 3, 32'h000F_FFFF, 32'h0, 32'h0, 3, 15, 27, 32'h0700_0000, 1'b0);
    end

    for (int k = 0; k < 500 && q.size() > 0; k++) @(posedge Clk);
    repeat (2) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
